// File: rtl/bin2bcd_seq_pkg.sv
// Shared BCD constants and elaboration helpers for the binary-to-BCD converter
// and the display blocks it feeds.
package bin2bcd_seq_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_NINE    = 4'h9;
  localparam logic [3:0] BCD_ADJ_MIN = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD = 4'd3;

  // 10^n as a 64-bit constant; used to fold the overflow limit at elaboration.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_dabble_digit.sv
// One double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next digit. Purely combinational.
module bcd_dabble_digit
  import bin2bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] dig_i,
  output logic [BCD_DIGIT_W-1:0] dig_o
);

  always_comb begin
    dig_o = dig_i;
    if (dig_i >= BCD_ADJ_MIN) begin
      dig_o = dig_i + BCD_ADJ_ADD;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per clock;
// the BCD result is registered and held between conversions, saturating to all nines.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W   = 14,
  parameter int DIS_NUM = 4
) (
  input  logic                           clk_i,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic [BIN_W-1:0]               i_bin,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [DIS_NUM*BCD_DIGIT_W-1:0] o_bcd_data,
  output logic                           o_overflow
);

  localparam int               BCD_W    = DIS_NUM * BCD_DIGIT_W;
  localparam int               CNT_W    = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
  localparam logic [63:0]      LIMIT    = pow10(DIS_NUM);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [BIN_W-1:0]  shreg_q, shreg_d;
  logic [BCD_W-1:0]  scratch_q, scratch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              ovf_q, ovf_d;

  logic [BCD_W-1:0]  scratch_adj;
  logic [BCD_W-1:0]  scratch_shifted;
  logic [63:0]       bin_ext;

  for (genvar g = 0; g < DIS_NUM; g++) begin : g_digit
    bcd_dabble_digit u_digit (
      .dig_i (scratch_q  [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dig_o (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // When 2^BIN_W <= 10^DIS_NUM this compare is constant false and folds away.
  assign bin_ext         = 64'(i_bin);
  assign scratch_shifted = {scratch_adj[BCD_W-2:0], shreg_q[BIN_W-1]};

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d    = ST_SHIFT;
          shreg_d    = i_bin;
          scratch_d  = '0;
          cnt_d      = '0;
          ovf_pend_d = (bin_ext >= LIMIT);
          busy_d     = 1'b1;
        end
      end
      ST_SHIFT: begin
        scratch_d = scratch_shifted;
        shreg_d   = shreg_q << 1;
        cnt_d     = cnt_q + CNT_W'(1);
        // The last shift publishes its own post-shift scratch in the same edge.
        if (cnt_q == LAST_CNT) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ovf_d   = ovf_pend_q;
          bcd_d   = ovf_pend_q ? {DIS_NUM{BCD_NINE}} : scratch_shifted;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_bcd_data = bcd_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and random checks of bin2bcd_seq against an arithmetic decimal model.
module tb_bin2bcd_seq;

  localparam int BIN_W   = 14;
  localparam int DIS_NUM = 4;
  localparam int LAT     = BIN_W;

  logic        clk_i;
  logic        i_rst_n;
  logic        i_start;
  logic [13:0] i_bin;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_bcd_data;
  logic        o_overflow;

  int          n_checks;
  int          n_fail;
  logic [15:0] last_bcd;
  logic        last_ovf;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIS_NUM(DIS_NUM)) dut (
    .clk_i      (clk_i),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_bin      (i_bin),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_bcd_data (o_bcd_data),
    .o_overflow (o_overflow)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Decimal digits by division, saturating above 9999.
  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    int          t;
    r = 16'h0;
    if (v > 9999) return 16'h9999;
    t = v;
    for (int i = 0; i < DIS_NUM; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts negedges until o_done; outputs must hold and busy stay high meanwhile.
  task automatic wait_done(input bit toggle, output int cyc);
    cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk_i);
      if (o_done) begin
        cyc = c;
        break;
      end
      chk("hold_bcd", 32'(o_bcd_data), 32'(last_bcd));
      chk("hold_ovf", 32'(o_overflow), 32'(last_ovf));
      chk("busy_during", 32'(o_busy), 32'd1);
      if (toggle) i_bin = 14'($urandom);
    end
  endtask

  task automatic check_result(input int v, input int cyc);
    chk("latency", 32'(cyc), 32'(LAT));
    chk("bcd", 32'(o_bcd_data), 32'(ref_bcd(v)));
    chk("ovf", 32'(o_overflow), 32'(v > 9999));
    chk("busy_at_done", 32'(o_busy), 32'd0);
    last_bcd = ref_bcd(v);
    last_ovf = (v > 9999);
  endtask

  // b2b: caller is on the done negedge and issues the next start into that cycle.
  task automatic convert(input int v, input bit b2b, output int total);
    int cyc;
    if (!b2b) begin
      @(negedge clk_i);
      chk("done_one_cycle", 32'(o_done), 32'd0);
      chk("idle_busy", 32'(o_busy), 32'd0);
    end
    i_bin   = 14'(v);
    i_start = 1'b1;
    @(negedge clk_i);
    i_start = 1'b0;
    i_bin   = 14'($urandom);
    chk("busy_after_accept", 32'(o_busy), 32'd1);
    wait_done(1'b0, cyc);
    check_result(v, cyc);
    total = (cyc < 0) ? -1 : cyc + 1;
  endtask

  initial begin
    int total;
    int cyc;
    int v;
    n_checks = 0;
    n_fail   = 0;
    last_bcd = 16'h0;
    last_ovf = 1'b0;
    i_rst_n  = 1'b0;
    i_start  = 1'b0;
    i_bin    = '0;

    #1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_bcd", 32'(o_bcd_data), 32'd0);
    chk("rst_ovf", 32'(o_overflow), 32'd0);
    repeat (3) @(negedge clk_i);
    i_rst_n = 1'b1;

    convert(1234, 1'b0, total);

    convert(0, 1'b0, total);
    convert(9999, 1'b1, total);
    chk("b2b_gap", 32'(total), 32'(LAT + 1));

    convert(10000, 1'b0, total);
    convert(16383, 1'b0, total);
    convert(42, 1'b0, total);

    // Start held high, input wandering while busy: only 777 must be converted.
    @(negedge clk_i);
    i_bin   = 14'd777;
    i_start = 1'b1;
    @(negedge clk_i);
    chk("held_busy", 32'(o_busy), 32'd1);
    wait_done(1'b1, cyc);
    i_start = 1'b0;
    check_result(777, cyc);

    convert(5678, 1'b0, total);
    @(negedge clk_i);
    i_bin   = 14'd321;
    i_start = 1'b1;
    @(negedge clk_i);
    i_start = 1'b0;
    repeat (5) @(negedge clk_i);
    i_rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    chk("abort_bcd", 32'(o_bcd_data), 32'd0);
    chk("abort_ovf", 32'(o_overflow), 32'd0);
    repeat (2) @(negedge clk_i);
    i_rst_n  = 1'b1;
    last_bcd = 16'h0;
    last_ovf = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      chk("abort_no_done", 32'(o_done), 32'd0);
      chk("abort_idle", 32'(o_busy), 32'd0);
    end
    convert(321, 1'b0, total);

    for (int i = 0; i < 40; i++) begin
      bit b2b;
      v   = int'($urandom_range(0, 16383));
      b2b = (i > 0) && ($urandom_range(0, 1) == 1);
      convert(v, b2b, total);
      if (b2b) chk("rand_b2b_gap", 32'(total), 32'(LAT + 1));
    end

    @(negedge clk_i);
    chk("final_done_low", 32'(o_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
